music_player: RTL

- Playback-side reader for the sample RAM that music_init fills.
- After init completes and start is pulsed, it reads 16-bit samples from addresses 0..music_len-1 at a fixed sample rate and drives them onto speaker_data, each with a strobe.
- It sits between the sample RAM read port and the speaker/PWM stage.
- It optionally loops and optionally applies a volume attenuation.

---
 rtl/music_player.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/music_player.sv
// music_player: streams samples from the sample RAM to the speaker at SAMPLE_HZ.
// Optional build macro MUSIC_PLAYER_VOLUME_EN adds a 3-bit arithmetic-shift volume input.
module music_player #(
   parameter int CLK_HZ    = 27000000,
   parameter int SAMPLE_HZ = 8000,
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 16,
   parameter int RAM_LAT   = 1
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              init_done,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] music_len,
`ifdef MUSIC_PLAYER_VOLUME_EN
   input  logic [2:0]        vol,
`endif
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_data_out,
   output logic [DATA_W-1:0] speaker_data,
   output logic              sample_strobe,
   output logic              busy,
   output logic              done
);

   localparam int DIV = CLK_HZ / SAMPLE_HZ;
   localparam int TW  = $clog2(DIV);
   localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);
   localparam logic [1:0]    LAT_MAX  = 2'(RAM_LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WAIT_DATA,
      HOLD
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_len;
   logic [ADDR_W-1:0] r_addr;
   logic [TW-1:0]     r_tick;
   logic [1:0]        r_lat;
   logic              r_last;
   logic              r_rd_en;
   logic [DATA_W-1:0] r_spk;
   logic              r_strobe;
   logic              r_busy;
   logic              r_done;

   logic [DATA_W-1:0] w_sample;
   logic              w_wrap;
   logic              w_at_end;

`ifdef MUSIC_PLAYER_VOLUME_EN
   assign w_sample = DATA_W'($signed(ram_data_out) >>> vol);
`else
   assign w_sample = ram_data_out;
`endif

   assign w_wrap   = (r_tick == TICK_MAX);
   assign w_at_end = (r_addr == r_len - ADDR_W'(1));

   // r_last marks the trailing period: one more "slot" runs with no read, then done.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state  <= IDLE;
         r_len    <= '0;
         r_addr   <= '0;
         r_tick   <= '0;
         r_lat    <= '0;
         r_last   <= 1'b0;
         r_rd_en  <= 1'b0;
         r_spk    <= '0;
         r_strobe <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_rd_en  <= 1'b0;
         r_strobe <= 1'b0;
         r_done   <= 1'b0;
         if (r_state != IDLE)
            r_tick <= w_wrap ? '0 : r_tick + TW'(1);
         if (stop && r_state != IDLE) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_spk   <= '0;
            r_tick  <= '0;
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (start && !stop && init_done) begin
                     if (music_len == '0) begin
                        r_done <= 1'b1;
                     end else begin
                        r_len   <= music_len;
                        r_addr  <= '0;
                        r_tick  <= '0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                        r_state <= READ;
                     end
                  end
               end
               READ: begin
                  r_lat   <= '0;
                  r_state <= WAIT_DATA;
               end
               WAIT_DATA: begin
                  if (r_lat == LAT_MAX) begin
                     if (r_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_spk   <= '0;
                        r_tick  <= '0;
                        r_state <= IDLE;
                     end else begin
                        r_spk    <= w_sample;
                        r_strobe <= 1'b1;
                        r_state  <= HOLD;
                        if (w_at_end) begin
                           if (loop_en)
                              r_addr <= '0;
                           else
                              r_last <= 1'b1;
                        end else begin
                           r_addr <= r_addr + ADDR_W'(1);
                        end
                     end
                  end else begin
                     r_lat <= r_lat + 2'd1;
                  end
               end
               HOLD: begin
                  if (w_wrap) begin
                     r_rd_en <= !r_last;
                     r_state <= READ;
                  end
               end
            endcase
         end
      end
   end

   assign ram_rd_en     = r_rd_en;
   assign ram_addr      = r_addr;
   assign speaker_data  = r_spk;
   assign sample_strobe = r_strobe;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule
